// File: rtl/if_stage.sv
// Instruction fetch stage: issues word-aligned fetches to instruction memory,
// pairs in-order responses with their PCs and buffers them for decode.
// Credits bound requests in flight plus buffered entries to DEPTH. Redirects
// flush the buffer and mark the remaining in-flight responses for discard.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = CW + 1;

  logic [31:0]   pc_q;
  logic [31:0]   pcq_mem [DEPTH];
  logic [IW-1:0] pcq_rd;
  logic [IW-1:0] pcq_wr;
  logic [CW-1:0] pcq_cnt;
  logic [CW-1:0] disc_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];

  logic [CW-1:0] outst;
  logic [SW-1:0] used;
  logic [CW-1:0] disc_redir;
  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_live;
  logic          pop;
  logic [CW-1:0] fifo_cnt_n;
  logic [IW-1:0] fifo_wr_idx;
  logic [31:0]   fifo_pc_n    [DEPTH];
  logic [31:0]   fifo_instr_n [DEPTH];

  // Wrapping pointer increment for the PC queue.
  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(DEPTH - 1)) ? '0 : p + IW'(1);
  endfunction

  assign imem_req_addr = pc_q;
  assign id_pc         = fifo_pc[0];
  assign id_instr      = fifo_instr[0];

  // Credit check and handshake decode; stale responses bypass the PC queue.
  always_comb begin
    outst          = pcq_cnt + disc_cnt;
    used           = SW'(outst) + SW'(fifo_cnt);
    imem_req_valid = rstn && !redirect_valid && (used < SW'(DEPTH));
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_drop       = imem_rsp_valid && !redirect_valid && (disc_cnt != '0);
    rsp_live       = imem_rsp_valid && !redirect_valid && (disc_cnt == '0) && (pcq_cnt != '0);
    pop            = id_valid && id_ready && !redirect_valid;
    disc_redir     = outst - CW'(imem_rsp_valid && (outst != '0));
  end

  // Decode buffer next state: head at entry 0, shift on pop, write behind tail.
  always_comb begin
    fifo_pc_n    = fifo_pc;
    fifo_instr_n = fifo_instr;
    fifo_cnt_n   = fifo_cnt + CW'(rsp_live) - CW'(pop);
    fifo_wr_idx  = IW'(fifo_cnt - CW'(pop));
    if (pop) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        fifo_pc_n[i]    = fifo_pc[i + 1];
        fifo_instr_n[i] = fifo_instr[i + 1];
      end
    end
    if (rsp_live) begin
      fifo_pc_n[fifo_wr_idx]    = pcq_mem[pcq_rd];
      fifo_instr_n[fifo_wr_idx] = imem_rsp_data;
    end
  end

  // Fetch PC, PC queue, discard count and decode buffer; redirect overrides all.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q     <= RESET_PC;
      pcq_rd   <= '0;
      pcq_wr   <= '0;
      pcq_cnt  <= '0;
      disc_cnt <= '0;
      fifo_cnt <= '0;
      id_valid <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pcq_mem[i]    <= '0;
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc_q     <= {redirect_target[31:2], 2'b00};
      pcq_rd   <= '0;
      pcq_wr   <= '0;
      pcq_cnt  <= '0;
      disc_cnt <= disc_redir;
      fifo_cnt <= '0;
      id_valid <= 1'b0;
    end else begin
      if (req_fire) begin
        pc_q            <= pc_q + 32'd4;
        pcq_mem[pcq_wr] <= pc_q;
        pcq_wr          <= ptr_inc(pcq_wr);
      end
      if (rsp_live) begin
        pcq_rd <= ptr_inc(pcq_rd);
      end
      pcq_cnt <= pcq_cnt + CW'(req_fire) - CW'(rsp_live);
      if (rsp_drop) begin
        disc_cnt <= disc_cnt - CW'(1);
      end
      fifo_cnt   <= fifo_cnt_n;
      id_valid   <= (fifo_cnt_n != '0);
      fifo_pc    <= fifo_pc_n;
      fifo_instr <= fifo_instr_n;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: in-order memory model with random latency, an epoch-based
// reference of the expected PC stream and credit usage, and a negedge monitor.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  if_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_pc           (id_pc),
    .id_instr        (id_instr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model configuration.
  int unsigned rdy_pct = 100;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;

  // Memory in-flight requests (address, cycle its response may appear, epoch).
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          pend_ep[$];

  // Scoreboard: expected request addresses and expected decode PCs.
  logic [31:0] exp_req[$];
  logic [31:0] exp_id[$];
  logic [31:0] nxt_req = RESET_PC;
  logic [31:0] nxt_id  = RESET_PC;
  int          buf_cnt = 0;
  int          epoch   = 0;
  int          n_req   = 0;
  int          n_pop   = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction memory: random ready, in-order responses no earlier than due.
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(pend_addr[0]);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
    end
  end

  // Monitor: compare outputs against the model, then apply this cycle's events.
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_req_addr", imem_req_addr, RESET_PC);
      chk("rst_id_valid", 32'(id_valid), 32'd0);
      chk("rst_id_pc", id_pc, 32'd0);
      chk("rst_id_instr", id_instr, 32'd0);
      pend_addr.delete();
      pend_due.delete();
      pend_ep.delete();
      exp_req.delete();
      exp_id.delete();
      buf_cnt = 0;
      nxt_req = RESET_PC;
      nxt_id  = RESET_PC;
    end else begin
      chk("req_valid", 32'(imem_req_valid),
          32'(!redirect_valid && (pend_addr.size() + buf_cnt < int'(DEPTH))));
      chk("id_valid", 32'(id_valid), 32'(buf_cnt != 0));
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req[0]);
      if (id_valid) begin
        chk("id_pc", id_pc, exp_id[0]);
        chk("id_instr", id_instr, instr_of(exp_id[0]));
      end
      if (imem_rsp_valid && pend_addr.size() != 0) begin
        if (!redirect_valid && pend_ep[0] == epoch) buf_cnt = buf_cnt + 1;
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
        void'(pend_ep.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        void'(exp_req.pop_front());
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        pend_ep.push_back(epoch);
        n_req = n_req + 1;
      end
      if (id_valid && id_ready && !redirect_valid && buf_cnt > 0) begin
        void'(exp_id.pop_front());
        buf_cnt = buf_cnt - 1;
        n_pop   = n_pop + 1;
      end
      if (redirect_valid) begin
        epoch   = epoch + 1;
        buf_cnt = 0;
        exp_req.delete();
        exp_id.delete();
        nxt_req = {redirect_target[31:2], 2'b00};
        nxt_id  = {redirect_target[31:2], 2'b00};
      end
    end
    while (exp_req.size() < 4) begin
      exp_req.push_back(nxt_req);
      nxt_req = nxt_req + 32'd4;
    end
    while (exp_id.size() < 4) begin
      exp_id.push_back(nxt_id);
      nxt_id = nxt_id + 32'd4;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
    tick(1);
    redirect_valid  = 1'b0;
  endtask

  int base;

  // Directed scenarios followed by a randomized run.
  initial begin
    rstn            = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    id_ready        = 1'b1;
    #1 rstn = 1'b0;
    tick(3);
    rstn = 1'b1;

    // Streaming from reset with a 1-cycle memory.
    base = n_pop;
    tick(12);
    chk("stream_progress", 32'(n_pop - base >= 3), 32'd1);

    // Decode stalled: only DEPTH requests may issue, head holds.
    id_ready = 1'b0;
    apply_reset();
    base = n_req;
    tick(5);
    chk("stall_req_count", 32'(n_req - base), 32'(DEPTH));
    id_ready = 1'b1;

    // Redirect with two requests outstanding.
    lat_min = 4;
    lat_max = 4;
    apply_reset();
    for (int i = 0; i < 20 && pend_addr.size() < 2; i++) tick(1);
    chk("outstanding_before_redirect", 32'(pend_addr.size()), 32'd2);
    redirect_to(32'h0000_0100);
    base = n_pop;
    tick(20);
    chk("redirect_progress", 32'(n_pop > base), 32'd1);

    // Redirect coinciding with a response; misaligned target.
    lat_min = 2;
    lat_max = 2;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      #1;
      if (imem_rsp_valid) break;
    end
    chk("rsp_at_redirect", 32'(imem_rsp_valid), 32'd1);
    redirect_to(32'h0000_0103);
    base = n_pop;
    tick(20);
    chk("redirect_rsp_progress", 32'(n_pop > base), 32'd1);

    // Wrap of the fetch PC.
    lat_min = 1;
    lat_max = 1;
    redirect_to(32'hFFFF_FFFC);
    base = n_pop;
    tick(12);
    chk("wrap_progress", 32'(n_pop - base >= 3), 32'd1);

    // Reset asserted in the middle of a memory stall.
    rdy_pct = 0;
    tick(3);
    rstn = 1'b0;
    tick(2);
    rdy_pct = 100;
    rstn = 1'b1;
    base = n_pop;
    tick(10);
    chk("post_reset_progress", 32'(n_pop > base), 32'd1);

    // Randomized traffic with occasional redirects.
    lat_min = 1;
    lat_max = 4;
    rdy_pct = 70;
    base = n_pop;
    for (int c = 0; c < 2000; c++) begin
      id_ready        = ($urandom_range(99) < 75);
      redirect_valid  = ($urandom_range(99) < 4);
      redirect_target = $urandom;
      tick(1);
    end
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    tick(20);
    chk("random_progress", 32'(n_pop - base > 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
